// File: rtl/tri_pkg.sv
// Shared widths and payload types for triangle assembly: vertex and triangle
// records plus small min/max helpers used for the bounding box.
package tri_pkg;

    localparam int unsigned COORD_W = 9;
    localparam int unsigned DIFF_W  = COORD_W + 1;
    localparam int unsigned PROD_W  = 2 * DIFF_W;
    localparam int unsigned AREA_W  = 21;
    localparam int unsigned NVERT   = 3;
    localparam int unsigned CNT_W   = 16;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t z;
    } vertex_t;

    typedef struct packed {
        vertex_t [NVERT-1:0] v;
        coord_t              min_x;
        coord_t              min_y;
        coord_t              max_x;
        coord_t              max_y;
    } tri_t;

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/tri_fifo.sv
// Show-ahead triangle FIFO with a registered head entry; a push is accepted
// while full whenever a pop happens in the same cycle.
module tri_fifo
    import tri_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  tri_t push_data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output tri_t head_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    tri_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    tri_t          head_q, head_d;
    logic          pop_ok, push_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = empty_q;
    assign head_o  = head_q;

    // Next-state: pointers, occupancy and the show-ahead head entry.
    always_comb begin
        pop_ok   = pop_i && !empty_q;
        push_ok  = push_i && (!full_o || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // New data goes straight to the head when it becomes the oldest entry.
        if (push_ok && ((count_q == '0) || (pop_ok && (count_q == CW'(1)))))
            head_d = push_data_i;
        else if (pop_ok && (count_q > CW'(1)))
            head_d = mem_q[rd_ptr_d];
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/tri_assemble.sv
// Groups projected vertices into triangles, computes signed area and bbox in a
// three-stage pipeline, culls, and buffers survivors for the rasterizer.
module tri_assemble
    import tri_pkg::*;
#(
    parameter bit          CULL_BACK  = 1'b1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [NVERT-1:0][COORD_W-1:0] vert_in,
    input  logic                          vert_valid_in,
    input  logic                          obj_done_in,
    output logic [NVERT-1:0][COORD_W-1:0] tri_x_out,
    output logic [NVERT-1:0][COORD_W-1:0] tri_y_out,
    output logic [NVERT-1:0][COORD_W-1:0] tri_z_out,
    output logic [COORD_W-1:0]            bbox_min_x_out,
    output logic [COORD_W-1:0]            bbox_min_y_out,
    output logic [COORD_W-1:0]            bbox_max_x_out,
    output logic [COORD_W-1:0]            bbox_max_y_out,
    output logic                          tri_valid_out,
    input  logic                          tri_ready_in,
    output logic                          obj_done_out,
    output logic [CNT_W-1:0]              culled_count_out,
    output logic                          overflow_out
);

    // Collect stage
    logic [1:0] cnt_q, cnt_d;
    vertex_t    slot0_q, slot0_d;
    vertex_t    slot1_q, slot1_d;
    vertex_t    vin;
    tri_t       new_tri;
    logic       launch;

    // Pipeline stages
    logic                      s1_vld_q, s2_vld_q, s3_vld_q;
    tri_t                      s1_tri_q, s2_tri_q, s3_tri_q;
    logic signed [DIFF_W-1:0]  dx1_q, dy1_q, dx2_q, dy2_q;
    logic signed [DIFF_W-1:0]  dx1_d, dy1_d, dx2_d, dy2_d;
    logic signed [PROD_W-1:0]  p0_q, p1_q, p0_d, p1_d;
    logic signed [AREA_W-1:0]  area_q, area_d;

    // Output side
    logic             cull_c, push_c, pop_c;
    logic             fifo_full, fifo_empty;
    tri_t             fifo_head;
    logic [CNT_W-1:0] culled_q, culled_d;
    logic             overflow_q, overflow_d;
    logic             pending_q, pending_d;
    logic             obj_done_q, fire_c;

    assign vin = '{x: vert_in[2], y: vert_in[1], z: vert_in[0]};

    // Vertex counter; an end-of-object pulse discards any partial triangle.
    always_comb begin
        cnt_d   = cnt_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        launch  = 1'b0;
        if (obj_done_in) begin
            cnt_d = 2'd0;
        end else if (vert_valid_in) begin
            case (cnt_q)
                2'd0: begin
                    slot0_d = vin;
                    cnt_d   = 2'd1;
                end
                2'd1: begin
                    slot1_d = vin;
                    cnt_d   = 2'd2;
                end
                default: begin
                    launch = 1'b1;
                    cnt_d  = 2'd0;
                end
            endcase
        end
    end

    assign new_tri.v[0]  = slot0_q;
    assign new_tri.v[1]  = slot1_q;
    assign new_tri.v[2]  = vin;
    assign new_tri.min_x = min3(slot0_q.x, slot1_q.x, vin.x);
    assign new_tri.min_y = min3(slot0_q.y, slot1_q.y, vin.y);
    assign new_tri.max_x = max3(slot0_q.x, slot1_q.x, vin.x);
    assign new_tri.max_y = max3(slot0_q.y, slot1_q.y, vin.y);

    // Edge-function terms relative to v0; zero-extended so differences are signed.
    assign dx1_d  = DIFF_W'(slot1_q.x) - DIFF_W'(slot0_q.x);
    assign dy1_d  = DIFF_W'(slot1_q.y) - DIFF_W'(slot0_q.y);
    assign dx2_d  = DIFF_W'(vin.x) - DIFF_W'(slot0_q.x);
    assign dy2_d  = DIFF_W'(vin.y) - DIFF_W'(slot0_q.y);
    assign p0_d   = PROD_W'(dx1_q) * PROD_W'(dy2_q);
    assign p1_d   = PROD_W'(dx2_q) * PROD_W'(dy1_q);
    assign area_d = AREA_W'(p0_q) - AREA_W'(p1_q);

    assign cull_c = (area_q == '0) || (CULL_BACK && area_q[AREA_W-1]);
    assign push_c = s3_vld_q && !cull_c;
    assign pop_c  = !fifo_empty && tri_ready_in;

    assign culled_d   = (s3_vld_q && cull_c) ? culled_q + CNT_W'(1) : culled_q;
    assign overflow_d = overflow_q || (push_c && fifo_full && !pop_c);

    // Completion fires once everything issued before the pulse has left the block.
    assign fire_c    = pending_q && !s1_vld_q && !s2_vld_q && !s3_vld_q && fifo_empty;
    assign pending_d = (pending_q || obj_done_in) && !fire_c;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q      <= '0;
            slot0_q    <= '0;
            slot1_q    <= '0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s3_vld_q   <= 1'b0;
            s1_tri_q   <= '0;
            s2_tri_q   <= '0;
            s3_tri_q   <= '0;
            dx1_q      <= '0;
            dy1_q      <= '0;
            dx2_q      <= '0;
            dy2_q      <= '0;
            p0_q       <= '0;
            p1_q       <= '0;
            area_q     <= '0;
            culled_q   <= '0;
            overflow_q <= 1'b0;
            pending_q  <= 1'b0;
            obj_done_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            s1_vld_q   <= launch;
            s1_tri_q   <= new_tri;
            dx1_q      <= dx1_d;
            dy1_q      <= dy1_d;
            dx2_q      <= dx2_d;
            dy2_q      <= dy2_d;
            s2_vld_q   <= s1_vld_q;
            s2_tri_q   <= s1_tri_q;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            s3_vld_q   <= s2_vld_q;
            s3_tri_q   <= s2_tri_q;
            area_q     <= area_d;
            culled_q   <= culled_d;
            overflow_q <= overflow_d;
            pending_q  <= pending_d;
            obj_done_q <= fire_c;
        end
    end

    tri_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .push_i     (push_c),
        .push_data_i(s3_tri_q),
        .pop_i      (pop_c),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (fifo_head)
    );

    for (genvar g = 0; g < NVERT; g++) begin : g_out
        assign tri_x_out[g] = fifo_head.v[g].x;
        assign tri_y_out[g] = fifo_head.v[g].y;
        assign tri_z_out[g] = fifo_head.v[g].z;
    end

    assign bbox_min_x_out   = fifo_head.min_x;
    assign bbox_min_y_out   = fifo_head.min_y;
    assign bbox_max_x_out   = fifo_head.max_x;
    assign bbox_max_y_out   = fifo_head.max_y;
    assign tri_valid_out    = !fifo_empty;
    assign obj_done_out     = obj_done_q;
    assign culled_count_out = culled_q;
    assign overflow_out     = overflow_q;

endmodule

// File: tb/tb_tri_assemble.sv
// Directed bench for tri_assemble: two instances (back-face culling on/off)
// share one stimulus stream; expected values are hand-computed constants.
module tb_tri_assemble;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic            rst_in, vert_valid_in, obj_done_in, tri_ready_in;
    logic [2:0][8:0] vert_in;

    logic [2:0][8:0] cb_x, cb_y, cb_z, nc_x, nc_y, nc_z;
    logic [8:0]      cb_minx, cb_miny, cb_maxx, cb_maxy;
    logic [8:0]      nc_minx, nc_miny, nc_maxx, nc_maxy;
    logic            cb_valid, cb_done, cb_ovf, nc_valid, nc_done, nc_ovf;
    logic [15:0]     cb_culled, nc_culled;

    int checks = 0;
    int errors = 0;
    int done_cb = 0, done_nc = 0, acc_cb = 0, acc_nc = 0;
    int d0_cb, d0_nc, a0_cb, a0_nc;

    tri_assemble #(.CULL_BACK(1'b1), .FIFO_DEPTH(4)) dut_cb (
        .clk_in(clk_in), .rst_in(rst_in), .vert_in(vert_in),
        .vert_valid_in(vert_valid_in), .obj_done_in(obj_done_in),
        .tri_x_out(cb_x), .tri_y_out(cb_y), .tri_z_out(cb_z),
        .bbox_min_x_out(cb_minx), .bbox_min_y_out(cb_miny),
        .bbox_max_x_out(cb_maxx), .bbox_max_y_out(cb_maxy),
        .tri_valid_out(cb_valid), .tri_ready_in(tri_ready_in),
        .obj_done_out(cb_done), .culled_count_out(cb_culled), .overflow_out(cb_ovf)
    );

    tri_assemble #(.CULL_BACK(1'b0), .FIFO_DEPTH(4)) dut_nc (
        .clk_in(clk_in), .rst_in(rst_in), .vert_in(vert_in),
        .vert_valid_in(vert_valid_in), .obj_done_in(obj_done_in),
        .tri_x_out(nc_x), .tri_y_out(nc_y), .tri_z_out(nc_z),
        .bbox_min_x_out(nc_minx), .bbox_min_y_out(nc_miny),
        .bbox_max_x_out(nc_maxx), .bbox_max_y_out(nc_maxy),
        .tri_valid_out(nc_valid), .tri_ready_in(tri_ready_in),
        .obj_done_out(nc_done), .culled_count_out(nc_culled), .overflow_out(nc_ovf)
    );

    // Event tallies sampled mid-cycle.
    always @(negedge clk_in) begin
        if (cb_done) done_cb++;
        if (nc_done) done_nc++;
        if (cb_valid && tri_ready_in) acc_cb++;
        if (nc_valid && tri_ready_in) acc_nc++;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int x, input int y, input int z);
        vert_in       = {9'(x), 9'(y), 9'(z)};
        vert_valid_in = 1'b1;
        tick();
        vert_valid_in = 1'b0;
    endtask

    task automatic chk_tri(input string tag, input bit use_nc, input logic [26:0] ex,
                           input logic [26:0] ey, input logic [26:0] ez, input logic [35:0] eb);
        if (use_nc) begin
            check({tag, "_vld"}, 36'(nc_valid), 36'd1);
            check({tag, "_x"}, 36'(nc_x), 36'(ex));
            check({tag, "_y"}, 36'(nc_y), 36'(ey));
            check({tag, "_z"}, 36'(nc_z), 36'(ez));
            check({tag, "_bb"}, {nc_minx, nc_miny, nc_maxx, nc_maxy}, eb);
        end else begin
            check({tag, "_vld"}, 36'(cb_valid), 36'd1);
            check({tag, "_x"}, 36'(cb_x), 36'(ex));
            check({tag, "_y"}, 36'(cb_y), 36'(ey));
            check({tag, "_z"}, 36'(cb_z), 36'(ez));
            check({tag, "_bb"}, {cb_minx, cb_miny, cb_maxx, cb_maxy}, eb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in = 1'b1; vert_valid_in = 1'b0; obj_done_in = 1'b0;
        tri_ready_in = 1'b1; vert_in = '0;
        tick(); tick();
        check("rst_cb_vld", 36'(cb_valid), 36'd0);
        check("rst_nc_vld", 36'(nc_valid), 36'd0);
        check("rst_culled", 36'(cb_culled), 36'd0);
        check("rst_ovf", 36'(cb_ovf), 36'd0);
        check("rst_done", 36'(cb_done), 36'd0);
        rst_in = 1'b0;

        // Front-facing triangle, area +100
        send(10, 10, 5); send(20, 10, 5); send(10, 20, 5);
        tick(); tick();
        check("t1_early_vld", 36'(cb_valid), 36'd0);
        tick();
        chk_tri("t1_cb", 1'b0, {9'd10, 9'd20, 9'd10}, {9'd20, 9'd10, 9'd10},
                {9'd5, 9'd5, 9'd5}, {9'd10, 9'd10, 9'd20, 9'd20});
        chk_tri("t1_nc", 1'b1, {9'd10, 9'd20, 9'd10}, {9'd20, 9'd10, 9'd10},
                {9'd5, 9'd5, 9'd5}, {9'd10, 9'd10, 9'd20, 9'd20});
        check("t1_cb_culled", 36'(cb_culled), 36'd0);
        tick();

        // Back-facing, area -100
        send(10, 10, 5); send(10, 20, 5); send(20, 10, 5);
        tick(); tick(); tick();
        check("t2_cb_vld", 36'(cb_valid), 36'd0);
        check("t2_cb_culled", 36'(cb_culled), 36'd1);
        check("t2_nc_culled", 36'(nc_culled), 36'd0);
        chk_tri("t2_nc", 1'b1, {9'd20, 9'd10, 9'd10}, {9'd10, 9'd20, 9'd10},
                {9'd5, 9'd5, 9'd5}, {9'd10, 9'd10, 9'd20, 9'd20});
        tick();

        // Collinear, area 0
        send(0, 0, 0); send(5, 5, 0); send(10, 10, 0);
        tick(); tick(); tick();
        check("t3_cb_vld", 36'(cb_valid), 36'd0);
        check("t3_nc_vld", 36'(nc_valid), 36'd0);
        check("t3_cb_culled", 36'(cb_culled), 36'd2);
        check("t3_nc_culled", 36'(nc_culled), 36'd1);

        // Partial triangle discarded by end-of-object
        d0_cb = done_cb; d0_nc = done_nc; a0_cb = acc_cb; a0_nc = acc_nc;
        send(100, 100, 1); send(200, 100, 1);
        obj_done_in = 1'b1;
        tick();
        obj_done_in = 1'b0;
        send(0, 0, 7);
        check("t4_cb_done", 36'(cb_done), 36'd1);
        check("t4_nc_done", 36'(nc_done), 36'd1);
        send(30, 0, 7);
        check("t4_done_pulse", 36'(cb_done), 36'd0);
        send(0, 40, 7);
        tick(); tick(); tick();
        chk_tri("t4_cb", 1'b0, {9'd0, 9'd30, 9'd0}, {9'd40, 9'd0, 9'd0},
                {9'd7, 9'd7, 9'd7}, {9'd0, 9'd0, 9'd30, 9'd40});
        chk_tri("t4_nc", 1'b1, {9'd0, 9'd30, 9'd0}, {9'd40, 9'd0, 9'd0},
                {9'd7, 9'd7, 9'd7}, {9'd0, 9'd0, 9'd30, 9'd40});
        tick();
        check("t4_cb_ndone", 36'(done_cb - d0_cb), 36'd1);
        check("t4_nc_ndone", 36'(done_nc - d0_nc), 36'd1);
        check("t4_cb_nacc", 36'(acc_cb - a0_cb), 36'd1);
        check("t4_nc_nacc", 36'(acc_nc - a0_nc), 36'd1);

        // Five triangles into a 4-deep FIFO with no consumer
        tri_ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(k * 10, 0, k); send(k * 10 + 20, 0, k); send(k * 10, 30, k);
        end
        tick(); tick(); tick();
        check("t5_cb_ovf", 36'(cb_ovf), 36'd1);
        check("t5_nc_ovf", 36'(nc_ovf), 36'd1);
        a0_cb = acc_cb;
        tri_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t5_cb_vld", 36'(cb_valid), 36'd1);
            check("t5_cb_x", 36'(cb_x), 36'({9'(k * 10), 9'(k * 10 + 20), 9'(k * 10)}));
            check("t5_cb_bb", {cb_minx, cb_miny, cb_maxx, cb_maxy},
                  {9'(k * 10), 9'd0, 9'(k * 10 + 20), 9'd30});
            check("t5_nc_x", 36'(nc_x), 36'({9'(k * 10), 9'(k * 10 + 20), 9'(k * 10)}));
            tick();
        end
        check("t5_drained", 36'(cb_valid), 36'd0);
        check("t5_ovf_sticky", 36'(cb_ovf), 36'd1);
        check("t5_cb_nacc", 36'(acc_cb - a0_cb), 36'd4);

        // Reset with two triangles queued and a partial vertex held
        tri_ready_in = 1'b0;
        send(10, 10, 1); send(20, 10, 1); send(10, 20, 1);
        send(30, 30, 2); send(40, 30, 2); send(30, 40, 2);
        send(400, 400, 9);
        tick(); tick();
        check("t6_pre_vld", 36'(cb_valid), 36'd1);
        check("t6_pre_x", 36'(cb_x), 36'({9'd10, 9'd20, 9'd10}));
        rst_in = 1'b1;
        tick();
        check("t6_rst_vld", 36'(cb_valid), 36'd0);
        check("t6_rst_culled", 36'(cb_culled), 36'd0);
        check("t6_rst_ovf", 36'(cb_ovf), 36'd0);
        check("t6_rst_x", 36'(cb_x), 36'd0);
        check("t6_rst_bb", {cb_minx, cb_miny, cb_maxx, cb_maxy}, 36'd0);
        check("t6_rst_nc_vld", 36'(nc_valid), 36'd0);
        rst_in = 1'b0;
        tri_ready_in = 1'b1;
        send(50, 60, 3); send(60, 60, 3); send(50, 70, 3);
        tick(); tick(); tick();
        chk_tri("t6_cb", 1'b0, {9'd50, 9'd60, 9'd50}, {9'd70, 9'd60, 9'd60},
                {9'd3, 9'd3, 9'd3}, {9'd50, 9'd60, 9'd60, 9'd70});
        chk_tri("t6_nc", 1'b1, {9'd50, 9'd60, 9'd50}, {9'd70, 9'd60, 9'd60},
                {9'd3, 9'd3, 9'd3}, {9'd50, 9'd60, 9'd60, 9'd70});

        // Back-to-back end-of-object pulses give one completion
        d0_cb = done_cb; d0_nc = done_nc;
        obj_done_in = 1'b1;
        tick(); tick();
        obj_done_in = 1'b0;
        tick(); tick(); tick(); tick();
        check("t7_cb_ndone", 36'(done_cb - d0_cb), 36'd1);
        check("t7_nc_ndone", 36'(done_nc - d0_nc), 36'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tri_assemble.md
Name: tri_assemble

Overview:
- Downstream of the vertex projection stage. Consumes projected 9-bit screen-space vertices (x, y, z) one at a time and groups every three consecutive vertices into a triangle.
- For each triangle it computes the signed area (edge function), culls degenerate and, optionally, back-facing triangles, and computes the screen bounding box.
- Surviving triangles are buffered in a small FIFO and presented to the rasterizer with a valid/ready handshake.
- The upstream projection stage has no backpressure, so this block absorbs rate mismatch. It flags overflow rather than stalling.

Parameters:
- CULL_BACK, 1: 1 = drop triangles with area < 0; 0 = keep them.
- FIFO_DEPTH, 4: triangle FIFO entries; power of two, ≥ 2.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- vert_in  input  [8:0] x3 array  projected vertex: [2]=x, [1]=y, [0]=z; unsigned screen coordinates.
- vert_valid_in  input  1  vert_in valid this cycle; single-cycle pulse per vertex.
- obj_done_in  input  1  end-of-object pulse.
- tri_x_out  output  [8:0] x3 array  x of v2, v1, v0 (index = vertex number).
- tri_y_out  output  [8:0] x3 array  y of v2, v1, v0.
- tri_z_out  output  [8:0] x3 array  z of v2, v1, v0.
- bbox_min_x_out, bbox_min_y_out, bbox_max_x_out, bbox_max_y_out  output  9 each  bounding box, inclusive.
- tri_valid_out  output  1  FIFO head valid.
- tri_ready_in  input  1  consumer accepts the head when tri_valid_out & tri_ready_in.
- obj_done_out  output  1  one-cycle pulse: object fully drained.
- culled_count_out  output  16  triangles culled since reset; wraps at 2^16.
- overflow_out  output  1  sticky: a triangle was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0, vertex counter 0, FIFO empty, pipeline valids 0, obj-done pending flag 0.
- Reset mid-operation discards any partial triangle, in-flight triangles and FIFO contents.
- Collect stage: 2-bit vertex counter (values 0→1→2→0). Each vert_valid_in stores the vertex in slot[count] and increments the counter.
  - When a vertex is stored at count = 2, the triangle launches into the pipeline in the same cycle (call it T) and the counter returns to 0.
  - The block accepts one vertex per cycle with no stall.
- Pipeline, fully pipelined, one triangle per cycle:
  - T+1: register signed 10-bit differences dx1=x1−x0, dy1=y1−y0, dx2=x2−x0, dy2=y2−y0. Compute bbox min/max via unsigned compares.
  - T+2: register signed 20-bit products p0=dx1·dy2 and p1=dx2·dy1.
  - T+3: area = p0−p1, signed 21-bit.
    - Cull if area == 0, or if CULL_BACK && area < 0.
    - Culled: culled_count_out increments.
    - Not culled: FIFO write.
- FIFO: show-ahead, registered head. With the FIFO empty and tri_ready_in high, tri_valid_out asserts in cycle T+4.
- Read and write in the same cycle are allowed at any occupancy, including full; the write succeeds when a read occurs.
- Write while full with no read: the triangle is dropped and overflow_out goes to 1 and stays at 1 until reset.
- Output data is stable while tri_valid_out && !tri_ready_in.
- obj_done_in:
  - Any partial triangle (count ≠ 0) is discarded and the counter is cleared.
  - The pending flag is set.
  - If vert_valid_in occurs in the same cycle, that vertex is discarded too.
- obj_done_out pulses for one cycle on the first cycle in which pending is set, all pipeline stages are empty and the FIFO is empty. Pending clears in that cycle.
- A second obj_done_in while pending is already set is absorbed, giving a single pulse.
- Vertices arriving while pending is set are accepted normally as the next object.

Decomposition:
- Package tri_pkg:
  - vertex_t struct {x, y, z: 9 bits}.
  - tri_t struct {v[3]: vertex_t; min/max x/y}.
  - COORD_W = 9 and AREA_W = 21.
- Sub-module tri_fifo: parameterised synchronous FIFO of tri_t. Ports: push, pop, full, empty, head data.

Test Plan:
- v0=(10,10,5), v1=(20,10,5), v2=(10,20,5), ready=1 → area=+100; tri_valid_out at T+4; bbox (10,10)–(20,20); culled_count stays 0.
- Same vertices ordered v0, v2, v1 with CULL_BACK=1 → area=−100; no output; culled_count=1. Repeat with CULL_BACK=0 → triangle emitted.
- Collinear (0,0,0), (5,5,0), (10,10,0) → area=0; culled in both CULL_BACK settings.
- Feed 2 vertices, pulse obj_done_in, then 3 new valid vertices → first two discarded; exactly one triangle emitted, built from the new vertices; one obj_done_out pulse, issued before that triangle launches.
- tri_ready_in=0, 5 valid triangles back-to-back (one vertex per cycle), FIFO_DEPTH=4 → 4 triangles held; 5th dropped; overflow_out=1. Then ready=1 → 4 triangles drained in order; overflow_out remains 1.
- Assert rst_in after 1 vertex and while the FIFO holds 2 triangles → next cycle: all outputs 0, FIFO empty; the following 3 vertices form a fresh triangle.
